// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// ALUOp/mux select codes and the control word driven to the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_ITYPE = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_zero;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // State that follows DECODE for a given opcode; S_FETCH marks an unsupported opcode.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t nxt;
    if (op == OP_LW || op == OP_SW)          nxt = S_MEM_ADDR;
    else if (op == OP_RTYPE)                 nxt = S_R_EXEC;
    else if (op >= OP_ADDI && op <= OP_XORI) nxt = S_I_EXEC;
    else if (op == OP_BEQ || op == OP_BNE)   nxt = S_BRANCH;
    else if (op == OP_J)                     nxt = S_JUMP;
    else                                     nxt = S_FETCH;
    return nxt;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decode from the current state, latched opcode,
// live opcode (for DECODE legality), ALU zero flag and memory completion.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  op_q,
  input  logic        zero,
  input  logic        mem_rdy,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_en     = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = ALUB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = (decode_target(opcode) == S_FETCH);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_rdy;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
        // andi/ori/xori share the 0011xx prefix and take a zero-extended immediate
        ctrl.ext_zero  = (op_q[5:2] == 4'b0011);
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.pc_en      = zero ^ op_q[0];
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, opcode latch, retired
// instruction counter; control outputs decoded from the registered state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             ext_zero,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       state_dbg
);

  state_t     state;
  logic [5:0] op_q;
  logic       mem_rdy;
  ctrl_t      ctrl;

  // Memory handshake: mem_read/mem_write stay asserted in a memory state and the
  // access completes on the cycle mem_ready is sampled high at the clock edge.
  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  mips_ctrl_outdec u_outdec (
    .state   (state),
    .opcode  (opcode),
    .op_q    (op_q),
    .zero    (zero),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_INIT;
      op_q          <= '0;
      retired_count <= '0;
    end else begin
      if (ctrl.instr_done) retired_count <= retired_count + CNT_W'(1);
      case (state)
        S_INIT:      state <= S_FETCH;
        S_FETCH:     if (mem_rdy) state <= S_DECODE;
        S_DECODE: begin
          op_q  <= opcode;
          state <= decode_target(opcode);
        end
        S_MEM_ADDR:  state <= (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_rdy) state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_rdy) state <= S_FETCH;
        S_R_EXEC:    state <= S_R_WB;
        S_I_EXEC:    state <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state <= S_FETCH;
        default:     state <= S_FETCH;
      endcase
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign pc_source  = ctrl.pc_source;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign ext_zero   = ctrl.ext_zero;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle vector table over every instruction
// class, then counter wrap and reset-during-store sequences.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, ext_zero, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] retired_count;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // clock/reset
  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_zero(ext_zero),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .retired_count(retired_count), .state_dbg(state_dbg)
  );

  wire [17:0] act_cw = {pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
                        mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, ext_zero,
                        instr_done, illegal_op};

  typedef struct {
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  st;
    logic [17:0] cw;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] cw(input logic pe, input logic [1:0] pcs,
      input logic io, input logic mr, input logic mw, input logic irw, input logic rd,
      input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic ez, input logic done, input logic ill);
    return {pe, pcs, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ez, done, ill};
  endfunction

  logic [17:0] e_idle, e_fetch_go, e_fetch_wait, e_decode, e_decode_ill, e_r_exec, e_r_wb;
  logic [17:0] e_mem_addr, e_mem_rd, e_mem_wb, e_mem_wr, e_mem_wr_done;
  logic [17:0] e_i_exec_z, e_i_exec, e_i_wb, e_br_t, e_br_n, e_jump;

  task automatic compare(input string name, input logic [3:0] st, input logic [17:0] ecw,
                         input logic [3:0] cnt);
    checks++;
    if ({state_dbg, act_cw, retired_count} !== {st, ecw, cnt}) begin
      errors++;
      $display("FAIL %s: got state=%0d cw=%h count=%0d, expected state=%0d cw=%h count=%0d",
               name, state_dbg, act_cw, retired_count, st, ecw, cnt);
    end
  endtask

  // driver: apply inputs after the rising edge, check on the falling edge
  task automatic step(input string name, input logic [5:0] op, input logic z,
                      input logic mr, input logic [3:0] st, input logic [17:0] ecw,
                      input logic [3:0] cnt);
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    @(negedge clk);
    compare(name, st, ecw, cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [17:0] ecw, input logic [3:0] cnt);
    vec_t v;
    v.opcode = op; v.zero = z; v.mem_ready = mr; v.st = st; v.cw = ecw; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  logic [3:0] exp_cnt;

  initial begin
    //            pe pcs   io mr mw irw rd m2r rw asa asb    aop    ez dn il
    e_idle        = '0;
    e_fetch_go    = cw(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0);
    e_fetch_wait  = cw(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0);
    e_decode      = cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b10, 0, 0, 0);
    e_decode_ill  = cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b10, 0, 0, 1);
    e_r_exec      = cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    e_r_wb        = cw(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0);
    e_mem_addr    = cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0);
    e_mem_rd      = cw(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    e_mem_wb      = cw(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1, 0);
    e_mem_wr      = cw(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    e_mem_wr_done = cw(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    e_i_exec_z    = cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 1, 0, 0);
    e_i_exec      = cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 0, 0, 0);
    e_i_wb        = cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0);
    e_br_t        = cw(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0, 1, 0);
    e_br_n        = cw(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0, 1, 0);
    e_jump        = cw(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);

    // add
    add(6'b000000, 0, 1, S_INIT,      e_idle,        4'd0);
    add(6'b000000, 0, 1, S_FETCH,     e_fetch_go,    4'd0);
    add(6'b000000, 0, 1, S_DECODE,    e_decode,      4'd0);
    add(6'b000000, 0, 1, S_R_EXEC,    e_r_exec,      4'd0);
    add(6'b000000, 0, 1, S_R_WB,      e_r_wb,        4'd0);
    // lw with two wait cycles in FETCH and in MEM_READ
    add(6'b100011, 0, 0, S_FETCH,     e_fetch_wait,  4'd1);
    add(6'b100011, 0, 0, S_FETCH,     e_fetch_wait,  4'd1);
    add(6'b100011, 0, 1, S_FETCH,     e_fetch_go,    4'd1);
    add(6'b100011, 0, 1, S_DECODE,    e_decode,      4'd1);
    add(6'b100011, 0, 1, S_MEM_ADDR,  e_mem_addr,    4'd1);
    add(6'b100011, 0, 0, S_MEM_READ,  e_mem_rd,      4'd1);
    add(6'b100011, 0, 0, S_MEM_READ,  e_mem_rd,      4'd1);
    add(6'b100011, 0, 1, S_MEM_READ,  e_mem_rd,      4'd1);
    add(6'b100011, 0, 1, S_MEM_WB,    e_mem_wb,      4'd1);
    // beq taken, bne not taken (zero=1)
    add(6'b000100, 1, 1, S_FETCH,     e_fetch_go,    4'd2);
    add(6'b000100, 1, 1, S_DECODE,    e_decode,      4'd2);
    add(6'b000100, 1, 1, S_BRANCH,    e_br_t,        4'd2);
    add(6'b000101, 1, 1, S_FETCH,     e_fetch_go,    4'd3);
    add(6'b000101, 1, 1, S_DECODE,    e_decode,      4'd3);
    add(6'b000101, 1, 1, S_BRANCH,    e_br_n,        4'd3);
    // ori then addi
    add(6'b001101, 0, 1, S_FETCH,     e_fetch_go,    4'd4);
    add(6'b001101, 0, 1, S_DECODE,    e_decode,      4'd4);
    add(6'b001101, 0, 1, S_I_EXEC,    e_i_exec_z,    4'd4);
    add(6'b001101, 0, 1, S_I_WB,      e_i_wb,        4'd4);
    add(6'b001000, 0, 1, S_FETCH,     e_fetch_go,    4'd5);
    add(6'b001000, 0, 1, S_DECODE,    e_decode,      4'd5);
    add(6'b001000, 0, 1, S_I_EXEC,    e_i_exec,      4'd5);
    add(6'b001000, 0, 1, S_I_WB,      e_i_wb,        4'd5);
    // illegal 111111, then j
    add(6'b111111, 0, 1, S_FETCH,     e_fetch_go,    4'd6);
    add(6'b111111, 0, 1, S_DECODE,    e_decode_ill,  4'd6);
    add(6'b000010, 0, 1, S_FETCH,     e_fetch_go,    4'd6);
    add(6'b000010, 0, 1, S_DECODE,    e_decode,      4'd6);
    add(6'b000010, 0, 1, S_JUMP,      e_jump,        4'd6);
    // sw with one wait in MEM_WRITE
    add(6'b101011, 0, 1, S_FETCH,     e_fetch_go,    4'd7);
    add(6'b101011, 0, 1, S_DECODE,    e_decode,      4'd7);
    add(6'b101011, 0, 1, S_MEM_ADDR,  e_mem_addr,    4'd7);
    add(6'b101011, 0, 0, S_MEM_WRITE, e_mem_wr,      4'd7);
    add(6'b101011, 0, 1, S_MEM_WRITE, e_mem_wr_done, 4'd7);
    // bne taken (zero=0), lui (001111) illegal, beq not taken (zero=0)
    add(6'b000101, 0, 1, S_FETCH,     e_fetch_go,    4'd8);
    add(6'b000101, 0, 1, S_DECODE,    e_decode,      4'd8);
    add(6'b000101, 0, 1, S_BRANCH,    e_br_t,        4'd8);
    add(6'b001111, 0, 1, S_FETCH,     e_fetch_go,    4'd9);
    add(6'b001111, 0, 1, S_DECODE,    e_decode_ill,  4'd9);
    add(6'b000100, 0, 1, S_FETCH,     e_fetch_go,    4'd9);
    add(6'b000100, 0, 1, S_DECODE,    e_decode,      4'd9);
    add(6'b000100, 0, 1, S_BRANCH,    e_br_n,        4'd9);
    add(6'b000000, 0, 0, S_FETCH,     e_fetch_wait,  4'd10);

    reset     = 1'b1;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    compare("reset_state", S_INIT, e_idle, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].opcode, vecs[i].zero, vecs[i].mem_ready,
           vecs[i].st, vecs[i].cw, vecs[i].cnt);

    // counter wrap: R-type instructions carry the 4-bit count 10 -> 15 -> 0 -> 1
    exp_cnt = 4'd10;
    for (int n = 0; n < 7; n++) begin
      step($sformatf("wrap%0d_fetch", n), 6'b000000, 0, 1, S_FETCH, e_fetch_go, exp_cnt);
      step($sformatf("wrap%0d_decode", n), 6'b000000, 0, 1, S_DECODE, e_decode, exp_cnt);
      step($sformatf("wrap%0d_exec", n), 6'b000000, 0, 1, S_R_EXEC, e_r_exec, exp_cnt);
      step($sformatf("wrap%0d_wb", n), 6'b000000, 0, 1, S_R_WB, e_r_wb, exp_cnt);
      exp_cnt = (exp_cnt == 4'd15) ? 4'd0 : exp_cnt + 4'd1;
    end

    // reset asserted while a store is waiting on memory
    step("rst_fetch", 6'b101011, 0, 1, S_FETCH, e_fetch_go, exp_cnt);
    step("rst_decode", 6'b101011, 0, 1, S_DECODE, e_decode, exp_cnt);
    step("rst_addr", 6'b101011, 0, 1, S_MEM_ADDR, e_mem_addr, exp_cnt);
    mem_ready = 1'b0;
    @(negedge clk);
    compare("rst_write_wait", S_MEM_WRITE, e_mem_wr, exp_cnt);
    #2;
    reset = 1'b1;
    #1;
    compare("rst_async_clear", S_INIT, e_idle, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rst_init", 6'b000000, 0, 1, S_INIT, e_idle, 4'd0);
    step("rst_refetch", 6'b000000, 0, 1, S_FETCH, e_fetch_go, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
